// File: rtl/lookup_arbiter_pkg.sv
// lookup_arb_pkg: shared types and default sizes for the lookup arbiter.
//   state_e     - arbiter FSM states (IDLE, ISSUE, WAIT, RESP)
//   *_DEF       - default port count, tuple width, mask width, timeout
package lookup_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_e;

  localparam int NPORT_DEF   = 4;
  localparam int TUPLE_W_DEF = 96;
  localparam int PORT_W_DEF  = 4;
  localparam int TIMEOUT_DEF = 16;

endpackage

// File: rtl/lookup_arbiter_if.sv
// lookup_arbiter_if: request/response channel to the shared lookup engine.
//   lk_req      - one-cycle lookup request (arbiter -> engine)
//   lk_tuple    - tuple under lookup, held from ISSUE through WAIT
//   lk_ack      - engine acknowledge (engine -> arbiter)
//   lk_fwd_port - forwarding mask, valid with lk_ack
// Modports: master = arbiter side, slave = engine side.
interface lookup_arbiter_if
  import lookup_arb_pkg::*;
#(
  parameter int TUPLE_W = TUPLE_W_DEF,
  parameter int PORT_W  = PORT_W_DEF
);
  logic               lk_req;
  logic [TUPLE_W-1:0] lk_tuple;
  logic               lk_ack;
  logic [PORT_W-1:0]  lk_fwd_port;

  modport master (output lk_req, output lk_tuple, input lk_ack, input lk_fwd_port);
  modport slave  (input lk_req, input lk_tuple, output lk_ack, output lk_fwd_port);
endinterface

// File: rtl/lookup_arbiter_rr_arbiter.sv
// rr_arbiter: combinational round-robin selector.
//   req   - request vector
//   ptr   - highest-priority index; priority ascends from here with wrap
//   grant - one-hot winner
//   idx   - winner index
//   any   - at least one request present
module rr_arbiter #(
  parameter int  NPORT = 4,
  localparam int IDXW  = $clog2(NPORT)
) (
  input  logic [NPORT-1:0] req,
  input  logic [IDXW-1:0]  ptr,
  output logic [NPORT-1:0] grant,
  output logic [IDXW-1:0]  idx,
  output logic             any
);
  localparam logic [IDXW:0] NP = (IDXW+1)'(NPORT);

  // pos[k] is the port index holding priority rank k (0 = highest).
  logic [IDXW-1:0] pos [NPORT];

  generate
    for (genvar gi = 0; gi < NPORT; gi++) begin : g_pos
      logic [IDXW:0] sum;
      assign sum     = {1'b0, ptr} + (IDXW+1)'(gi);
      assign pos[gi] = (sum >= NP) ? IDXW'(sum - NP) : IDXW'(sum);
    end
  endgenerate

  // Walk from lowest to highest priority so the last hit is the winner.
  always_comb begin
    grant = '0;
    idx   = '0;
    for (int k = NPORT - 1; k >= 0; k--) begin
      if (req[pos[k]]) begin
        grant         = '0;
        grant[pos[k]] = 1'b1;
        idx           = pos[k];
      end
    end
  end

  assign any = |req;
endmodule

// File: rtl/lookup_arbiter.sv
// lookup_arbiter: shares one flow-lookup engine among NPORT ingress ports.
//   sys_clk, sys_rst_n - clock, asynchronous active-low reset
//   in_req/in_tuple    - per-port request level and 96-bit tuples
//   in_ack/in_fwd_port - one-hot one-cycle response strobe and result mask
//   lk (master)        - engine request/response channel
//   busy               - high whenever the FSM is not IDLE
//   timeout_err        - pulse with in_ack on an aborted lookup
// Optional feature: define LOOKUP_ARB_TIMEOUT_EN to abort a lookup after
// TIMEOUT WAIT cycles without lk_ack (result 0, timeout_err=1).
module lookup_arbiter
  import lookup_arb_pkg::*;
#(
  parameter int NPORT   = NPORT_DEF,
  parameter int TUPLE_W = TUPLE_W_DEF,
  parameter int PORT_W  = PORT_W_DEF,
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input  logic                     sys_clk,
  input  logic                     sys_rst_n,
  input  logic [NPORT-1:0]         in_req,
  input  logic [NPORT*TUPLE_W-1:0] in_tuple,
  output logic [NPORT-1:0]         in_ack,
  output logic [PORT_W-1:0]        in_fwd_port,
  lookup_arbiter_if.master         lk,
  output logic                     busy,
  output logic                     timeout_err
);
  localparam int IDXW = $clog2(NPORT);

  state_e             state_q, state_d;
  logic [IDXW-1:0]    ptr_q, ptr_d;
  logic [IDXW-1:0]    g_q, g_d;
  logic [NPORT-1:0]   gnt_q, gnt_d;
  logic [TUPLE_W-1:0] tuple_q, tuple_d;
  logic               lk_req_q, lk_req_d;
  logic [NPORT-1:0]   ack_q, ack_d;
  logic [PORT_W-1:0]  fwd_q, fwd_d;
  logic               busy_q, busy_d;

  logic [NPORT-1:0]   win_grant;
  logic [IDXW-1:0]    win_idx;
  logic               win_any;

`ifdef LOOKUP_ARB_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT + 1);
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             err_q, err_d;
`else
  logic unused_timeout;
  assign unused_timeout = (TIMEOUT > 0);
`endif

  rr_arbiter #(.NPORT(NPORT)) u_rr (
    .req   (in_req),
    .ptr   (ptr_q),
    .grant (win_grant),
    .idx   (win_idx),
    .any   (win_any)
  );

  always_comb begin
    state_d  = state_q;
    ptr_d    = ptr_q;
    g_d      = g_q;
    gnt_d    = gnt_q;
    tuple_d  = tuple_q;
    lk_req_d = 1'b0;
    // Response outputs are nonzero only while in RESP.
    ack_d    = '0;
    fwd_d    = '0;
`ifdef LOOKUP_ARB_TIMEOUT_EN
    cnt_d    = cnt_q;
    err_d    = 1'b0;
`endif
    case (state_q)
      IDLE: begin
        if (win_any) begin
          g_d      = win_idx;
          gnt_d    = win_grant;
          tuple_d  = in_tuple[win_idx*TUPLE_W +: TUPLE_W];
          lk_req_d = 1'b1;
          state_d  = ISSUE;
        end
      end
      ISSUE: begin
        state_d = WAIT;
`ifdef LOOKUP_ARB_TIMEOUT_EN
        cnt_d   = '0;
`endif
      end
      WAIT: begin
        // lk_ack is only trusted here; elsewhere it may be stale or X.
        if (lk.lk_ack) begin
          ack_d   = gnt_q;
          fwd_d   = lk.lk_fwd_port;
          state_d = RESP;
        end
`ifdef LOOKUP_ARB_TIMEOUT_EN
        // cnt_q counts WAIT cycles already elapsed, so this is the last one.
        else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
          ack_d   = gnt_q;
          err_d   = 1'b1;
          state_d = RESP;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
`endif
      end
      RESP: begin
        ptr_d   = (g_q == IDXW'(NPORT - 1)) ? '0 : g_q + 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q  <= IDLE;
      ptr_q    <= '0;
      g_q      <= '0;
      gnt_q    <= '0;
      tuple_q  <= '0;
      lk_req_q <= 1'b0;
      ack_q    <= '0;
      fwd_q    <= '0;
      busy_q   <= 1'b0;
`ifdef LOOKUP_ARB_TIMEOUT_EN
      cnt_q    <= '0;
      err_q    <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      ptr_q    <= ptr_d;
      g_q      <= g_d;
      gnt_q    <= gnt_d;
      tuple_q  <= tuple_d;
      lk_req_q <= lk_req_d;
      ack_q    <= ack_d;
      fwd_q    <= fwd_d;
      busy_q   <= busy_d;
`ifdef LOOKUP_ARB_TIMEOUT_EN
      cnt_q    <= cnt_d;
      err_q    <= err_d;
`endif
    end
  end

  assign lk.lk_req   = lk_req_q;
  assign lk.lk_tuple = tuple_q;
  assign in_ack      = ack_q;
  assign in_fwd_port = fwd_q;
  assign busy        = busy_q;
`ifdef LOOKUP_ARB_TIMEOUT_EN
  assign timeout_err = err_q;
`else
  assign timeout_err = 1'b0;
`endif
endmodule
